line_fetch: RTL
===============

LINE_FETCH -- requirements
Module: line_fetch

Interface
REQ-001 SHALL have parameter WORDS_PER_LINE, default 320, 16-bit PSDRAM words per scanline.
REQ-002 SHALL have parameter LINES, default 480, valid line count.
REQ-003 SHALL have parameter WAIT_CYCLES, default 3, read wait states per word (1..15).
REQ-004 SHALL have parameter BASE_ADDR, default 0, 23-bit frame base word address.
REQ-005 SHALL have port clk  input  1  single system clock, all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port line_req  input  1  one-cycle pulse requesting a fetch of line_num.
REQ-008 SHALL have port line_num  input  10  line to fetch, sampled with line_req.
REQ-009 SHALL have port swap  input  1  one-cycle pulse exchanging front and back buffers.
REQ-010 SHALL have port rd_addr  input  10  front-buffer pixel index 0..639.
REQ-011 SHALL have port rd_pixel  output  8  front-buffer pixel (palette index).
REQ-012 SHALL have ports MemOE, MemWR, RamCE, RamLB, RamUB  output  1 each  PSDRAM controls, active-low.
REQ-013 SHALL have ports MemAdr  output  23  word address; MemDataIn  input  16  read data.
REQ-014 SHALL have ports busy  output  1; line_done  output  1 (one-cycle pulse); overrun_err  output  1 (sticky).

Function
REQ-015 SHALL hold two 640x8 buffers; buf_sel selects front (read) and back (write).
REQ-016 SHALL return rd_pixel = front[rd_addr] registered, one cycle after rd_addr.
REQ-017 SHALL implement FSM IDLE, SETUP, WAIT, CAPTURE, NEXT, DONE.
REQ-018 IDLE->SETUP on line_req with line_num < LINES; word index k cleared; busy high in all states except IDLE.
REQ-019 SETUP: MemAdr = (BASE_ADDR + line_num*WORDS_PER_LINE + k) truncated to 23 bits; RamCE=0, MemOE=0.
REQ-020 WAIT SHALL last exactly WAIT_CYCLES cycles with CE/OE held low, then go to CAPTURE.
REQ-021 CAPTURE SHALL write MemDataIn[7:0] to back[2k], MemDataIn[15:8] to back[2k+1].
REQ-022 NEXT SHALL drive RamCE=1, MemOE=1 for one cycle; k==WORDS_PER_LINE-1 -> DONE, else k+1 -> SETUP.
REQ-023 DONE SHALL pulse line_done for one cycle and return to IDLE; per-line latency WORDS_PER_LINE*(WAIT_CYCLES+3)+2 cycles (1922 at defaults).
REQ-024 MemWR SHALL be 1 and RamLB/RamUB 0 at all times after reset.
REQ-025 line_req with line_num >= LINES SHALL cause no memory access; line_done pulses next cycle, back buffer unchanged.
REQ-026 line_req while busy SHALL be ignored.
REQ-027 swap while idle SHALL toggle buf_sel; swap while busy SHALL be ignored and set overrun_err.
REQ-028 swap and line_req in the same IDLE cycle: swap applied first, fetch fills the new back buffer.

Reset
REQ-029 reset low SHALL immediately force IDLE, RamCE=MemOE=MemWR=1, RamLB=RamUB=0, MemAdr=0, busy=0, line_done=0, overrun_err=0, buf_sel=0, rd_pixel=0.
REQ-030 Reset mid-fetch SHALL abandon the line; buffer contents undefined, no line_done.

Configuration
REQ-031 With LINE_FETCH_TESTPAT_EN defined, CAPTURE SHALL write back[p] = p[7:0] XOR line_num[7:0] instead of MemDataIn, RamCE/MemOE staying high, FSM timing unchanged.
REQ-032 Without LINE_FETCH_TESTPAT_EN, behaviour SHALL be as REQ-019..REQ-022.

Verification
REQ-033 Memory model word = {addr[7:0]+1, addr[7:0]}; line_req line_num=2, swap after line_done -> rd_addr 0 gives 0x80, rd_addr 1 gives 0x81 (addr 640).
REQ-034 line_req line_num=0 at defaults -> line_done exactly 1922 cycles after req; MemAdr sequence 0..319; CE low 4 cycles per word.
REQ-035 swap pulsed 100 cycles into a fetch -> buf_sel unchanged, overrun_err=1 and held until reset.
REQ-036 line_req line_num=480 -> no CE low, line_done next cycle; second line_req during busy -> no extra line_done.
REQ-037 reset low at word 150 -> CE/OE high same cycle, busy=0, no line_done; new fetch after release completes normally.
REQ-038 LINE_FETCH_TESTPAT_EN build, line_num=3 -> pixel 5 reads 0x06, RamCE never low.

Source files
------------

// File: rtl/line_fetch.sv
// line_fetch: fetches one scanline of 16-bit PSDRAM words into the back half
// of a double-buffered 2x640x8 pixel store. The front half is read out
// registered. Optional build macro LINE_FETCH_TESTPAT_EN replaces memory data
// with a pixel-index XOR line-number pattern and keeps the PSDRAM deselected.
module line_fetch #(
    parameter int unsigned WORDS_PER_LINE = 320,
    parameter int unsigned LINES          = 480,
    parameter int unsigned WAIT_CYCLES    = 3,
    parameter logic [22:0] BASE_ADDR      = 23'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        line_req,
    input  logic [9:0]  line_num,
    input  logic        swap,
    input  logic [9:0]  rd_addr,
    output logic [7:0]  rd_pixel,
    output logic        MemOE,
    output logic        MemWR,
    output logic        RamCE,
    output logic        RamLB,
    output logic        RamUB,
    output logic [22:0] MemAdr,
    input  logic [15:0] MemDataIn,
    output logic        busy,
    output logic        line_done,
    output logic        overrun_err
);

    localparam int unsigned AW  = 23;
    localparam int unsigned PIX = 2 * WORDS_PER_LINE;
    localparam int unsigned KW  = $clog2(WORDS_PER_LINE);
    localparam int unsigned PW  = KW + 1;

`ifdef LINE_FETCH_TESTPAT_EN
    localparam logic CE_ACT = 1'b1;
`else
    localparam logic CE_ACT = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT,
        S_CAPTURE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [KW-1:0]   r_k;
    logic [3:0]      r_wcnt;
    logic [AW-1:0]   r_base;
    logic            r_buf_sel;
    logic            r_ce;
    logic            r_oe;
    logic [AW-1:0]   r_adr;
    logic            r_busy;
    logic            r_done;
    logic            r_ovr;
    logic [7:0]      r_pixel;
`ifdef LINE_FETCH_TESTPAT_EN
    logic [7:0]      r_line;
`else
    logic [15:0]     r_data;
`endif

    logic [7:0]      r_buf0 [PIX];
    logic [7:0]      r_buf1 [PIX];

    logic [AW-1:0]   w_line_base;
    logic [PW-1:0]   w_p0;
    logic [PW-1:0]   w_p1;
    logic [7:0]      w_lo;
    logic [7:0]      w_hi;
    logic [7:0]      w_front;

    assign w_line_base = AW'(32'(BASE_ADDR) + 32'(line_num) * WORDS_PER_LINE);

    // Write-side pixel pair for the current word
    always_comb begin
        w_p0 = PW'({r_k, 1'b0});
        w_p1 = w_p0 | PW'(1);
`ifdef LINE_FETCH_TESTPAT_EN
        w_lo = w_p0[7:0] ^ r_line;
        w_hi = w_p1[7:0] ^ r_line;
`else
        w_lo = r_data[7:0];
        w_hi = r_data[15:8];
`endif
    end

    // Front-buffer lookup; out-of-range indices read as zero
    always_comb begin
        w_front = '0;
        if (rd_addr < 10'(PIX)) begin
            w_front = r_buf_sel ? r_buf1[rd_addr] : r_buf0[rd_addr];
        end
    end

    // Fetch sequencer with registered PSDRAM controls and status
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_k       <= '0;
            r_wcnt    <= '0;
            r_base    <= '0;
            r_buf_sel <= 1'b0;
            r_ce      <= 1'b1;
            r_oe      <= 1'b1;
            r_adr     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ovr     <= 1'b0;
`ifdef LINE_FETCH_TESTPAT_EN
            r_line    <= '0;
`else
            r_data    <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            if (swap) begin
                if (r_state == S_IDLE) begin
                    r_buf_sel <= ~r_buf_sel;
                end else begin
                    r_ovr <= 1'b1;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (line_req) begin
                        if (32'(line_num) < LINES) begin
                            r_state <= S_SETUP;
                            r_busy  <= 1'b1;
                            r_k     <= '0;
                            r_base  <= w_line_base;
                            r_adr   <= w_line_base;
                            r_ce    <= CE_ACT;
                            r_oe    <= CE_ACT;
`ifdef LINE_FETCH_TESTPAT_EN
                            r_line  <= line_num[7:0];
`endif
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                S_SETUP: begin
                    r_state <= S_WAIT;
                    r_wcnt  <= '0;
                end
                S_WAIT: begin
                    if (r_wcnt == 4'(WAIT_CYCLES - 1)) begin
                        r_state <= S_CAPTURE;
                        r_ce    <= 1'b1;
                        r_oe    <= 1'b1;
`ifndef LINE_FETCH_TESTPAT_EN
                        r_data  <= MemDataIn;
`endif
                    end else begin
                        r_wcnt <= r_wcnt + 4'd1;
                    end
                end
                S_CAPTURE: begin
                    r_state <= S_NEXT;
                end
                S_NEXT: begin
                    if (r_k == KW'(WORDS_PER_LINE - 1)) begin
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_SETUP;
                        r_k     <= r_k + KW'(1);
                        r_adr   <= r_base + AW'(r_k) + AW'(1);
                        r_ce    <= CE_ACT;
                        r_oe    <= CE_ACT;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Back-buffer write of the captured word's two pixels
    always_ff @(posedge clk) begin
        if (r_state == S_CAPTURE) begin
            if (r_buf_sel) begin
                r_buf0[w_p0] <= w_lo;
                r_buf0[w_p1] <= w_hi;
            end else begin
                r_buf1[w_p0] <= w_lo;
                r_buf1[w_p1] <= w_hi;
            end
        end
    end

    // Registered front-buffer read port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pixel <= '0;
        end else begin
            r_pixel <= w_front;
        end
    end

    assign rd_pixel    = r_pixel;
    assign RamCE       = r_ce;
    assign MemOE       = r_oe;
    assign MemAdr      = r_adr;
    assign busy        = r_busy;
    assign line_done   = r_done;
    assign overrun_err = r_ovr;
    assign MemWR       = 1'b1;
    assign RamLB       = 1'b0;
    assign RamUB       = 1'b0;

endmodule
